fwd_hazard_unit: RTL and testbench

Forwarding and load-use hazard unit for the 5-stage RISC-V core. It sits in the ID stage and tracks destination tags of the instructions in EX and MEM. Each cycle it produces the registered `sr1_mux_sel_fh` / `sr2_mux_sel_fh` codes consumed by the operand-select merge logic in EX. It also generates the ID stall and EX bubble for load-use hazards.

---
 rtl/fwd_hazard_unit.sv | 159 +++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding / load-use hazard unit: tracks EX and MEM destination tags and
// produces registered operand-select codes. Optional macro: FH_NPC_FWD_EN.
module fwd_hazard_unit #(
    parameter int XLEN_REGS = 5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 pipe_hold,
    input  logic                 ex_flush,
    input  logic                 id_valid,
    input  logic [XLEN_REGS-1:0] id_rs1,
    input  logic [XLEN_REGS-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [XLEN_REGS-1:0] id_rd,
    input  logic                 id_rd_we,
    input  logic [1:0]           id_wb_src,
    output logic [2:0]           sr1_mux_sel_fh,
    output logic [2:0]           sr2_mux_sel_fh,
    output logic                 stall_id,
    output logic                 bubble_ex
);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_DM   = 2'b01;
    localparam logic [1:0] SRC_NPC  = 2'b10;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_ALU1 = 3'b100;
    localparam logic [2:0] SEL_WB2  = 3'b101;
    localparam logic [2:0] SEL_DM2  = 3'b110;
    localparam logic [2:0] SEL_NPC1 = 3'b111;

    logic                 slot_ex_v_q,  slot_ex_v_d;
    logic [XLEN_REGS-1:0] slot_ex_rd_q, slot_ex_rd_d;
    logic [1:0]           slot_ex_src_q, slot_ex_src_d;
    logic                 slot_mem_v_q,  slot_mem_v_d;
    logic [XLEN_REGS-1:0] slot_mem_rd_q, slot_mem_rd_d;
    logic [1:0]           slot_mem_src_q, slot_mem_src_d;
    logic [2:0]           sel1_q, sel1_d;
    logic [2:0]           sel2_q, sel2_d;

    logic [3:0]           fwd1_s;
    logic [3:0]           fwd2_s;
    logic                 hazard_s;
    logic                 id_tag_v_s;
    logic [1:0]           id_src_s;

    // Returns {load_use_hazard, select_code} for one source operand.
    function automatic logic [3:0] fwd_lookup(
        input logic                 used,
        input logic [XLEN_REGS-1:0] rs,
        input logic                 ex_v,
        input logic [XLEN_REGS-1:0] ex_rd,
        input logic [1:0]           ex_src,
        input logic                 mem_v,
        input logic [XLEN_REGS-1:0] mem_rd,
        input logic [1:0]           mem_src
    );
        logic [3:0] res;
        res = {1'b0, SEL_NONE};
        if (!used || (rs == {XLEN_REGS{1'b0}})) begin
            res = {1'b0, SEL_NONE};
        end else if (ex_v && (ex_rd == rs)) begin
            case (ex_src)
                SRC_DM:  res = {1'b1, SEL_NONE};
`ifdef FH_NPC_FWD_EN
                SRC_NPC: res = {1'b0, SEL_NPC1};
`else
                SRC_NPC: res = {1'b1, SEL_NONE};
`endif
                default: res = {1'b0, SEL_ALU1};
            endcase
        end else if (mem_v && (mem_rd == rs)) begin
            if (mem_src == SRC_DM) begin
                res = {1'b0, SEL_DM2};
            end else begin
                res = {1'b0, SEL_WB2};
            end
        end else begin
            res = {1'b0, SEL_NONE};
        end
        return res;
    endfunction

    // Source lookup and the combinational stall/bubble controls.
    always_comb begin
        fwd1_s = fwd_lookup(id_valid & id_rs1_used, id_rs1,
                            slot_ex_v_q, slot_ex_rd_q, slot_ex_src_q,
                            slot_mem_v_q, slot_mem_rd_q, slot_mem_src_q);
        fwd2_s = fwd_lookup(id_valid & id_rs2_used, id_rs2,
                            slot_ex_v_q, slot_ex_rd_q, slot_ex_src_q,
                            slot_mem_v_q, slot_mem_rd_q, slot_mem_src_q);
        hazard_s   = fwd1_s[3] | fwd2_s[3];
        stall_id   = rstn & ~pipe_hold & ~ex_flush & hazard_s;
        bubble_ex  = rstn & ~pipe_hold & (ex_flush | hazard_s);
        id_tag_v_s = id_valid & id_rd_we & (id_rd != {XLEN_REGS{1'b0}});
        // Reserved writeback source behaves as ALU.
        id_src_s   = (id_wb_src == 2'b11) ? SRC_ALU : id_wb_src;
    end

    // Next-state selection: hold > flush/hazard (inject bubble) > advance.
    always_comb begin
        slot_ex_v_d    = slot_ex_v_q;
        slot_ex_rd_d   = slot_ex_rd_q;
        slot_ex_src_d  = slot_ex_src_q;
        slot_mem_v_d   = slot_mem_v_q;
        slot_mem_rd_d  = slot_mem_rd_q;
        slot_mem_src_d = slot_mem_src_q;
        sel1_d         = sel1_q;
        sel2_d         = sel2_q;
        if (pipe_hold) begin
            sel1_d = sel1_q;
        end else if (ex_flush || hazard_s) begin
            slot_mem_v_d   = slot_ex_v_q;
            slot_mem_rd_d  = slot_ex_rd_q;
            slot_mem_src_d = slot_ex_src_q;
            slot_ex_v_d    = 1'b0;
            sel1_d         = SEL_NONE;
            sel2_d         = SEL_NONE;
        end else begin
            slot_mem_v_d   = slot_ex_v_q;
            slot_mem_rd_d  = slot_ex_rd_q;
            slot_mem_src_d = slot_ex_src_q;
            slot_ex_v_d    = id_tag_v_s;
            slot_ex_rd_d   = id_rd;
            slot_ex_src_d  = id_src_s;
            sel1_d         = fwd1_s[2:0];
            sel2_d         = fwd2_s[2:0];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_ex_v_q    <= 1'b0;
            slot_ex_rd_q   <= {XLEN_REGS{1'b0}};
            slot_ex_src_q  <= SRC_ALU;
            slot_mem_v_q   <= 1'b0;
            slot_mem_rd_q  <= {XLEN_REGS{1'b0}};
            slot_mem_src_q <= SRC_ALU;
            sel1_q         <= SEL_NONE;
            sel2_q         <= SEL_NONE;
        end else begin
            slot_ex_v_q    <= slot_ex_v_d;
            slot_ex_rd_q   <= slot_ex_rd_d;
            slot_ex_src_q  <= slot_ex_src_d;
            slot_mem_v_q   <= slot_mem_v_d;
            slot_mem_rd_q  <= slot_mem_rd_d;
            slot_mem_src_q <= slot_mem_src_d;
            sel1_q         <= sel1_d;
            sel2_q         <= sel2_d;
        end
    end

    assign sr1_mux_sel_fh = sel1_q;
    assign sr2_mux_sel_fh = sel2_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, reset corner
// case, then random traffic against a pipeline-history reference model.
module tb_fwd_hazard_unit;

`ifdef FH_NPC_FWD_EN
    localparam bit NPC_FWD = 1'b1;
`else
    localparam bit NPC_FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       pipe_hold = 1'b0, ex_flush = 1'b0, id_valid = 1'b0;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_rd_we = 1'b0;
    logic [1:0] id_wb_src = 2'd0;
    logic [2:0] sr1_mux_sel_fh, sr2_mux_sel_fh;
    logic       stall_id, bubble_ex;

    fwd_hazard_unit #(.XLEN_REGS(5)) dut (
        .clk(clk), .rstn(rstn), .pipe_hold(pipe_hold), .ex_flush(ex_flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_wb_src(id_wb_src),
        .sr1_mux_sel_fh(sr1_mux_sel_fh), .sr2_mux_sel_fh(sr2_mux_sel_fh),
        .stall_id(stall_id), .bubble_ex(bubble_ex)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic h, f, v;
        logic [4:0] rs1, rs2;
        logic u1, u2;
        logic [4:0] rd;
        logic we;
        logic [1:0] src;
        logic es, eb;
        logic [2:0] s1, s2;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic h, f, v, input int rs1, rs2, input logic u1, u2,
                       input int rd, input logic we, input int src,
                       input logic es, eb, input int s1, s2);
        vec_t t;
        t.h = h; t.f = f; t.v = v;
        t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0]; t.u1 = u1; t.u2 = u2;
        t.rd = rd[4:0]; t.we = we; t.src = src[1:0];
        t.es = es; t.eb = eb; t.s1 = s1[2:0]; t.s2 = s2[2:0];
        vecs.push_back(t);
    endtask

    task automatic drive(input logic h, f, v, input logic [4:0] rs1, rs2,
                         input logic u1, u2, input logic [4:0] rd,
                         input logic we, input logic [1:0] src);
        pipe_hold = h; ex_flush = f; id_valid = v;
        id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_rd_we = we; id_wb_src = src;
    endtask

    // Reference model: the instructions now in EX (index 0) and MEM (index 1).
    typedef struct { bit v; bit we; int rd; int src; } instr_t;
    instr_t pipe_m[2];
    int     m_sel1, m_sel2;

    // Returns select code, or -1 when the operand needs a load-use stall.
    function automatic int model_fwd(bit valid, bit used, int rs);
        int s;
        if (!(valid && used && rs != 0)) return 0;
        for (int d = 1; d <= 2; d++) begin
            if (pipe_m[d-1].v && pipe_m[d-1].we && pipe_m[d-1].rd != 0 && pipe_m[d-1].rd == rs) begin
                s = (pipe_m[d-1].src == 3) ? 0 : pipe_m[d-1].src;
                if (d == 1) begin
                    if (s == 1) return -1;
                    if (s == 2) return NPC_FWD ? 7 : -1;
                    return 4;
                end
                return (s == 1) ? 6 : 5;
            end
        end
        return 0;
    endfunction

    initial begin
        int c1, c2;
        bit haz, prev_stall;
        instr_t id_i;

        // Directed table
        add(0,0,1, 0,0,1,0, 5,1,0, 0,0, 0,0);    // addi x5
        add(0,0,1, 5,5,1,1, 6,1,0, 0,0, 4,4);    // add x6,x5,x5
        add(0,0,1, 0,0,1,0, 7,1,1, 0,0, 0,0);    // lw x7
        add(0,0,1, 7,0,1,1, 8,1,0, 1,1, 0,0);    // add x8,x7,x0 : load-use
        add(0,0,1, 7,0,1,1, 8,1,0, 0,0, 6,0);    // retried
        add(0,0,1, 0,0,0,0, 1,1,2, 0,0, 0,0);    // jal x1
`ifdef FH_NPC_FWD_EN
        add(0,0,1, 1,0,1,0, 2,1,0, 0,0, 7,0);    // addi x2,x1,4
`else
        add(0,0,1, 1,0,1,0, 2,1,0, 1,1, 0,0);
        add(0,0,1, 1,0,1,0, 2,1,0, 0,0, 5,0);
`endif
        add(0,0,1, 0,0,1,0, 9,1,0, 0,0, 0,0);    // unrelated
        add(0,0,1, 2,0,1,1, 10,1,0, 0,0, 5,0);   // two-ahead ALU
        add(0,0,1, 0,0,1,0, 11,1,1, 0,0, 0,0);   // lw x11
        add(0,0,1, 0,0,1,0, 12,1,0, 0,0, 0,0);
        add(0,0,1, 11,11,1,1, 13,1,0, 0,0, 6,6); // two-ahead load
        add(0,0,1, 0,0,1,0, 13,1,3, 0,0, 0,0);   // x13 again, reserved src
        add(0,0,1, 13,13,1,1, 14,1,0, 0,0, 4,4); // both slots match
        add(0,0,1, 14,0,1,0, 0,1,0, 0,0, 4,0);   // write to x0
        add(0,0,1, 0,0,1,1, 15,1,0, 0,0, 0,0);   // reads x0
        add(0,0,1, 15,15,0,0, 16,1,0, 0,0, 0,0); // sources unused
        add(0,0,0, 16,15,1,1, 17,1,1, 0,0, 0,0); // id_valid=0
        add(0,0,1, 16,0,1,0, 18,0,1, 0,0, 5,0);  // rd_we=0
        add(0,0,1, 0,0,1,0, 17,1,1, 0,0, 0,0);   // lw x17
        add(0,1,1, 17,0,1,0, 18,1,0, 0,1, 0,0);  // flush over hazard
        add(0,0,1, 17,0,1,0, 20,1,0, 0,0, 6,0);
        add(0,0,1, 20,0,1,0, 19,1,1, 0,0, 4,0);  // lw x19,0(x20)
        add(1,0,1, 19,19,1,1, 21,1,0, 0,0, 4,0); // hold x3 mid-hazard
        add(1,0,1, 19,19,1,1, 21,1,0, 0,0, 4,0);
        add(1,0,1, 19,19,1,1, 21,1,0, 0,0, 4,0);
        add(0,0,1, 19,19,1,1, 21,1,0, 1,1, 0,0);
        add(0,0,1, 19,19,1,1, 21,1,0, 0,0, 6,6);

        // Reset state
        #1;
        check("rst_sel1", sr1_mux_sel_fh, 0);
        check("rst_sel2", sr2_mux_sel_fh, 0);
        check("rst_stall", stall_id, 0);
        check("rst_bubble", bubble_ex, 0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].h, vecs[i].f, vecs[i].v, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].u1, vecs[i].u2, vecs[i].rd, vecs[i].we, vecs[i].src);
            #4;
            check($sformatf("vec%0d_stall", i), stall_id, vecs[i].es);
            check($sformatf("vec%0d_bubble", i), bubble_ex, vecs[i].eb);
            @(posedge clk); #1;
            check($sformatf("vec%0d_sel1", i), sr1_mux_sel_fh, vecs[i].s1);
            check($sformatf("vec%0d_sel2", i), sr2_mux_sel_fh, vecs[i].s2);
        end

        // Asynchronous reset in the middle of a load-use stall
        drive(0,0,1, 5'd0,5'd0,1,0, 5'd22,1,2'd1);
        @(posedge clk); #1;
        drive(0,0,1, 5'd22,5'd0,1,0, 5'd23,1,2'd0);
        #3;
        check("rststall_pre", stall_id, 1);
        rstn = 1'b0;
        #1;
        check("rststall_stall", stall_id, 0);
        check("rststall_bubble", bubble_ex, 0);
        check("rststall_sel1", sr1_mux_sel_fh, 0);
        #2 rstn = 1'b1;
        #1;
        check("rststall_after", stall_id, 0);
        @(posedge clk); #1;
        check("rststall_sel_next", sr1_mux_sel_fh, 0);

        // Random traffic against the model (fresh reset)
        rstn = 1'b0;
        drive(0,0,0, 5'd0,5'd0,0,0, 5'd0,0,2'd0);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) pipe_m[k] = '{v:1'b0, we:1'b0, rd:0, src:0};
        m_sel1 = 0; m_sel2 = 0;
        prev_stall = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(7) == 0, $urandom_range(9) == 0, $urandom_range(7) != 0,
                  5'($urandom_range(7)), 5'($urandom_range(7)),
                  1'($urandom_range(1)), 1'($urandom_range(1)),
                  5'($urandom_range(7)), $urandom_range(3) != 0, 2'($urandom_range(3)));
            #4;
            c1 = model_fwd(id_valid, id_rs1_used, int'(id_rs1));
            c2 = model_fwd(id_valid, id_rs2_used, int'(id_rs2));
            haz = (c1 < 0) || (c2 < 0);
            check("rnd_stall", stall_id, !pipe_hold && !ex_flush && haz);
            check("rnd_bubble", bubble_ex, !pipe_hold && (ex_flush || haz));
            check("rnd_stall_run", prev_stall && stall_id, 0);
            prev_stall = stall_id;
            id_i = '{v:id_valid, we:id_rd_we, rd:int'(id_rd), src:int'(id_wb_src)};
            @(posedge clk);
            if (!pipe_hold) begin
                pipe_m[1] = pipe_m[0];
                if (ex_flush || haz) begin
                    pipe_m[0].v = 1'b0;
                    m_sel1 = 0; m_sel2 = 0;
                end else begin
                    pipe_m[0] = id_i;
                    m_sel1 = c1; m_sel2 = c2;
                end
            end
            #1;
            check("rnd_sel1", sr1_mux_sel_fh, m_sel1);
            check("rnd_sel2", sr2_mux_sel_fh, m_sel2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
